// File: rtl/alu3_rr_arbiter_pkg.sv
// Shared definitions for the alu3_rr_arbiter operand-select path.
// Optional build macro: ALU3_LOCK_EN (adds multi-beat lock support in the top).
package alu3_rr_arbiter_pkg;

  localparam int NUM_REQ = 3;

  // Selector codes; SEL_NONE marks a cycle with no grant.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Output stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Requester index that sits 'step' positions after 'base' in the circular
  // order a -> b -> c -> a. Inputs are at most 3 each, so two conditional
  // subtractions are enough to bring the sum back into 0..2.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/alu3_rr_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last and
// returns a one-hot grant plus the matching selector code.
module rr_pick3
  import alu3_rr_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  input  logic       i_enable,
  output logic [2:0] o_grant,
  output logic [1:0] o_idx
);

  // First requester found after the previous winner gets the grant.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_grant = '0;
    o_idx   = SEL_NONE;
    if (i_enable) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if ((o_grant == 3'b000) && i_req[rr_next(i_last, 2'(k))]) begin
          o_grant[rr_next(i_last, 2'(k))] = 1'b1;
          o_idx                           = rr_next(i_last, 2'(k));
        end
      end
    end
  end

endmodule

// File: rtl/alu3_rr_arbiter.sv
// Round-robin arbiter sharing one 3:1 operand-select path between requesters
// a, b, c, feeding a single-entry valid/ready output register.
// Optional build macro: ALU3_LOCK_EN adds req_lock[2:0]; the owner of the last
// transfer keeps the grant while its lock and valid bits stay set.
module alu3_rr_arbiter
  import alu3_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
`ifdef ALU3_LOCK_EN
  input  logic [2:0]        req_lock,
`endif
  output logic [2:0]        req_ready,
  input  logic [DATA_W-1:0] In_a,
  input  logic [DATA_W-1:0] In_b,
  input  logic [DATA_W-1:0] In_c,
  output logic [1:0]        Selector,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] OUT_ALU3,
  output logic [1:0]        out_src
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_last;
  logic [DATA_W-1:0] r_out;
  logic [1:0]        r_src;

  logic              w_enable;
  logic [2:0]        w_pick_req;
  logic [2:0]        w_grant;
  logic [1:0]        w_idx;
  logic              w_xfer;
  logic [DATA_W-1:0] w_operand;

  // Grants are only offered when the output stage can take a word, and never
  // while reset is held so req_ready stays low throughout reset.
  assign w_enable = ((r_state == EMPTY) | out_ready) & ~rst;

`ifdef ALU3_LOCK_EN
  logic r_has_owner;
  logic w_lock_hit;

  // A lock only counts for the requester that made the last transfer; masking
  // the request vector down to that one bit forces the picker onto it.
  assign w_lock_hit = r_has_owner & req_lock[r_last] & req_valid[r_last];
  assign w_pick_req = w_lock_hit ? (3'b001 << r_last) : req_valid;

  // Remember whether any transfer has happened since reset, i.e. whether an owner exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_has_owner <= 1'b0;
    else if (w_xfer) r_has_owner <= 1'b1;
  end
`else
  assign w_pick_req = req_valid;
`endif

  rr_pick3 u_pick (
    .i_req    (w_pick_req),
    .i_last   (r_last),
    .i_enable (w_enable),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_xfer    = (w_grant != 3'b000);
  assign req_ready = w_grant;
  assign Selector  = w_idx;

  // 3:1 operand select driven by the winner's code.
  always_comb begin
    w_operand = '0;
    case (w_idx)
      SEL_A:   w_operand = In_a;
      SEL_B:   w_operand = In_b;
      SEL_C:   w_operand = In_c;
      default: w_operand = '0;
    endcase
  end

  // Output-stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Occupancy next state: fill on a transfer, drain when consumed with nothing new.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_xfer) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Capture the winning operand, its source and the round-robin pointer on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data register is reset too, so OUT_ALU3 reads zero after reset rather than X.
    if (rst) begin
      r_out  <= '0;
      r_src  <= SEL_NONE;
      r_last <= SEL_C;
    end else if (w_xfer) begin
      r_out  <= w_operand;
      r_src  <= w_idx;
      r_last <= w_idx;
    end
  end

  assign out_valid = (r_state == FULL);
  assign OUT_ALU3  = r_out;
  assign out_src   = r_src;

endmodule

// File: tb/tb_alu3_rr_arbiter.sv
// Self-checking bench for alu3_rr_arbiter: directed stimulus pushes expected
// transfers into a queue, a negedge monitor pops and compares on each handshake.
module tb_alu3_rr_arbiter;

  localparam int DATA_W = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0]        req_lock;
  logic [2:0]        req_ready;
  logic [DATA_W-1:0] In_a, In_b, In_c;
  logic [1:0]        Selector;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] OUT_ALU3;
  logic [1:0]        out_src;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alu3_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
`ifdef ALU3_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .In_a      (In_a),
    .In_b      (In_b),
    .In_c      (In_c),
    .Selector  (Selector),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT_ALU3  (OUT_ALU3),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [1:0] s);
    exp_t e;
    e.data = d;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  // Monitor: the word visible before an edge with out_ready high is consumed at that edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(OUT_ALU3), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", 32'(OUT_ALU3), 32'(e.data));
        check("sb_src",  32'(out_src),  32'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]        rr_src [6];
    logic [DATA_W-1:0] rr_val [6];
    logic [1:0]        tail_src [4];

    rr_src = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    rr_val = '{6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd3};
`ifdef ALU3_LOCK_EN
    tail_src = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    tail_src = '{2'b01, 2'b10, 2'b00, 2'b01};
`endif

    // Reset state.
    rst = 1'b1; req_valid = '0; req_lock = '0; out_ready = 1'b0;
    In_a = '0; In_b = '0; In_c = '0;
    #2;
    check("rst_selector",  32'(Selector),  32'h3);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_alu3",  32'(OUT_ALU3),  32'h0);
    check("rst_out_src",   32'(out_src),   32'h3);
    #10;
    rst = 1'b0;

    // Idle after reset.
    out_ready = 1'b1;
    #1;
    check("idle_selector",  32'(Selector),  32'h3);
    check("idle_req_ready", 32'(req_ready), 32'h0);
    step();
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // All three requesting: a,b,c,a,b,c.
    req_valid = 3'b111; In_a = 6'd1; In_b = 6'd2; In_c = 6'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_selector", 32'(Selector), 32'(rr_src[i]));
      push(rr_val[i], rr_src[i]);
      step();
    end

    // Single request from b.
    req_valid = 3'b010; In_b = 6'h15;
    #1;
    check("single_req_ready", 32'(req_ready), 32'h2);
    check("single_selector",  32'(Selector),  32'h1);
    push(6'h15, 2'b01);
    step();
    check("single_out_valid", 32'(out_valid), 32'h1);
    check("single_out_alu3",  32'(OUT_ALU3),  32'h15);

    // Load 2A from c (pointer is at b, so c wins).
    req_valid = 3'b111; In_c = 6'h2A;
    #1;
    check("bp_load_selector", 32'(Selector), 32'h2);
    push(6'h2A, 2'b10);
    step();

    // Backpressure for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_selector",  32'(Selector),  32'h3);
      check("bp_out_alu3",  32'(OUT_ALU3),  32'h2A);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      step();
    end

    // Release: grant resumes at last+1 = a.
    out_ready = 1'b1; In_a = 6'h07;
    #1;
    check("resume_selector",  32'(Selector),  32'h0);
    check("resume_req_ready", 32'(req_ready), 32'h1);
    push(6'h07, 2'b00);
    step();

    // Async reset while FULL; in-flight word is discarded.
    out_ready = 1'b0; req_valid = 3'b000;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_out_src",   32'(out_src),   32'h3);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // First grant after reset goes to a (pointer would otherwise favour b).
    req_valid = 3'b111; out_ready = 1'b1;
    In_a = 6'h11; In_b = 6'h22; In_c = 6'h33;
    #1;
    check("post_rst_selector", 32'(Selector), 32'h0);
    push(6'h11, 2'b00);
    step();

    // Lock sequence on b (pure round-robin order in the default build).
    req_lock = 3'b010;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_lock = 3'b000;
      #1;
      check("tail_selector", 32'(Selector), 32'(tail_src[i]));
      case (tail_src[i])
        2'b00:   push(In_a, 2'b00);
        2'b01:   push(In_b, 2'b01);
        default: push(In_c, 2'b10);
      endcase
      step();
    end

    // Drain.
    req_valid = 3'b000;
    step();
    step();
    check("drain_out_valid", 32'(out_valid), 32'h0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu3_rr_arbiter.md
Name: alu3_rr_arbiter

Overview:
- Shares one 3:1 operand-select path between three requesters (a, b, c) using round-robin arbitration.
- Each cycle it drives the 2-bit selector code of the winner and accepts that requester's operand.
- The winning operand is registered into a single-entry output stage with a valid/ready handshake toward the downstream ALU stage.
- Sits between the operand sources and the ALU input register.

Parameters:
- DATA_W, 6: operand width; 32 in the full-width build.
- SEL_NONE, 2'b11: selector code driven when nothing is granted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  3  bit0=a, bit1=b, bit2=c; requester holds operand valid.
- req_ready  output  3  one-hot or zero; a requester's operand is accepted this cycle.
- In_a  input  DATA_W  operand of requester a.
- In_b  input  DATA_W  operand of requester b.
- In_c  input  DATA_W  operand of requester c.
- Selector  output  2  00=a, 01=b, 10=c, SEL_NONE=idle; combinational, matches req_ready.
- out_valid  output  1  output register holds an operand.
- out_ready  input  1  downstream consumes the operand this cycle.
- OUT_ALU3  output  DATA_W  registered operand.
- out_src  output  2  selector code of the requester that produced OUT_ALU3.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, OUT_ALU3=0, out_src=SEL_NONE.
  - Priority pointer last=2 (c), so a wins first.
  - State=EMPTY.
  - Combinational outputs follow: req_ready=0 until reset deasserts, Selector=SEL_NONE.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = (state==EMPTY) | out_ready.
- Grant, combinational:
  - If can_accept, grant the first set req_valid bit in circular order last+1, last+2, last.
  - Otherwise no grant.
  - req_ready = one-hot grant; Selector = grant index, else SEL_NONE.
- A transfer happens on a cycle with a grant. At the next rising edge:
  - OUT_ALU3 = granted operand; out_src = index; out_valid=1; last = index.
- Transitions:
  - EMPTY, grant -> FULL.
  - EMPTY, no grant -> EMPTY.
  - FULL, !out_ready -> FULL; OUT_ALU3 and out_src held stable.
  - FULL, out_ready & grant -> FULL with new data (back-to-back, 1 operand/cycle).
  - FULL, out_ready & no grant -> EMPTY; OUT_ALU3 keeps its old value; out_valid=0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 operand per cycle while out_ready stays high.
- Fairness: with all three requesting continuously and out_ready=1, the grant order is a,b,c,a,b,c... Maximum wait is 2 transfers.
- Requesters must hold valid and data until ready. Dropping valid without ready is legal; no grant occurs for it.
- The pointer updates only on a transfer, never on a stall.
- Reset mid-transfer: the in-flight operand is discarded, out_valid drops immediately (asynchronous), and the pointer returns to 2.
- Selector never encodes 2'b11 while req_ready is nonzero.

Optional Feature:
- Macro: ALU3_LOCK_EN.
- With the macro:
  - Extra input port req_lock[2:0].
  - If the last transfer's requester has its lock bit set and req_valid set, it wins the next grant regardless of round-robin, for multi-beat sequences.
  - A lock on a requester that is not the current owner is ignored.
  - The lock is released when the owner deasserts req_lock or req_valid.
  - The pointer still updates to the owner's index.
- Without the macro: no req_lock port; pure round-robin.

Decomposition:
- Shared package holds:
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_NONE=2'b11.
  - State typedef {EMPTY, FULL}.
  - NUM_REQ=3.
- One natural sub-module: rr_pick3.
  - Purely combinational.
  - Inputs: req[2:0], last[1:0], enable.
  - Outputs: one-hot grant and 2-bit index.
- The top module holds the output register, state and pointer.

Test Plan:
- Reset then idle: req_valid=000 -> Selector=11, req_ready=000, out_valid=0, OUT_ALU3=0.
- Single request: req_valid=010, In_b=6'h15, out_ready=1 -> same cycle req_ready=010, Selector=01; next cycle out_valid=1, OUT_ALU3=6'h15, out_src=01.
- All requesting, out_ready=1, In_a=1, In_b=2, In_c=3 for 6 cycles -> OUT_ALU3 sequence 1,2,3,1,2,3.
- Backpressure: FULL with OUT_ALU3=6'h2A, out_ready=0 for 3 cycles while req_valid=111 -> req_ready=000, Selector=11, OUT_ALU3 stays 2A; on out_ready=1 the grant resumes at last+1.
- Async reset pulsed mid-stream (between clock edges) while out_valid=1 -> out_valid=0 before the next edge; first grant after release goes to a.
- With ALU3_LOCK_EN: b granted with req_lock=010 and req_valid=111 for 3 cycles -> b granted 3 times; lock drops -> next grant goes to c.
